// File: rtl/gnr_pkg.sv
// Shared types and defaults for the GNR attractor sweep controller.
package gnr_pkg;

    localparam int N_NODES_DEF = 8;
    localparam int STEP_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_CHECK,
        ST_PERIOD,
        ST_RESULT,
        ST_DONE
    } gnr_state_t;

endpackage

// File: rtl/gnr_attractor_ctrl_if.sv
// Host/config, node-bank and result-stream signals of the attractor controller.
interface gnr_attractor_ctrl_if #(
    parameter int N_NODES = 8,
    parameter int STEP_W  = 16
);
    logic                start;
    logic [N_NODES-1:0]  cfg_first;
    logic [N_NODES-1:0]  cfg_last;
    logic [STEP_W-1:0]   cfg_max_steps;
    logic                reset_nos;
    logic                start_s0;
    logic                start_s1;
    logic [N_NODES-1:0]  init_state;
    logic [N_NODES-1:0]  alpha_s0;
    logic [N_NODES-1:0]  alpha_s1;
    logic                res_valid;
    logic                res_ready;
    logic [N_NODES-1:0]  res_init;
    logic [STEP_W-1:0]   res_steps;
    logic [STEP_W-1:0]   res_period;
    logic                res_timeout;
    logic                busy;
    logic                done;

    modport master (
        input  start, cfg_first, cfg_last, cfg_max_steps, alpha_s0, alpha_s1, res_ready,
        output reset_nos, start_s0, start_s1, init_state,
        output res_valid, res_init, res_steps, res_period, res_timeout, busy, done
    );

    modport slave (
        output start, cfg_first, cfg_last, cfg_max_steps, alpha_s0, alpha_s1, res_ready,
        input  reset_nos, start_s0, start_s1, init_state,
        input  res_valid, res_init, res_steps, res_period, res_timeout, busy, done
    );
endinterface

// File: rtl/gnr_step_counter.sv
// Clearable up-counter with equality compare against a run limit.
module gnr_step_counter #(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inc,
    input  logic [STEP_W-1:0] limit,
    output logic [STEP_W-1:0] count,
    output logic              at_limit
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + STEP_W'(1);
        end
    end

    assign at_limit = (count == limit);
endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Sweeps initial states through a GNR node bank and finds attractors by Floyd cycle detection.
// Define GNR_PERIOD_EN to additionally measure the attractor period after each match.
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int N_NODES = N_NODES_DEF,
    parameter int STEP_W  = STEP_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gnr_attractor_ctrl_if.master bus
);
    typedef struct packed {
        logic [N_NODES-1:0] init;
        logic [STEP_W-1:0]  steps;
        logic [STEP_W-1:0]  period;
        logic               timeout;
    } result_t;

    gnr_state_t          state_reg;
    logic [N_NODES-1:0]  cur_reg;
    logic [N_NODES-1:0]  last_reg;
    logic [STEP_W-1:0]   max_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                reset_nos_reg;
    logic                start_s0_reg;
    logic                start_s1_reg;
    logic [N_NODES-1:0]  init_state_reg;
    logic                res_valid_reg;
    result_t             res_reg;

    logic [STEP_W-1:0]   step_count;
    logic                step_at_limit;
    logic [STEP_W-1:0]   max_norm;
    logic                alpha_eq;
    logic                fin_go;
    logic                fin_timeout;
    logic [STEP_W-1:0]   fin_period;
    logic                go_period;
    logic [N_NODES-1:0]  cur_inc;

    assign max_norm = (bus.cfg_max_steps == '0) ? STEP_W'(1) : bus.cfg_max_steps;
    assign alpha_eq = (bus.alpha_s0 == bus.alpha_s1);
    assign cur_inc  = cur_reg + N_NODES'(1);

    gnr_step_counter #(.STEP_W(STEP_W)) u_step_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_reg == ST_LOAD),
        .inc      (state_reg == ST_STEP),
        .limit    (max_reg),
        .count    (step_count),
        .at_limit (step_at_limit)
    );

`ifdef GNR_PERIOD_EN
    logic                in_period_reg;
    logic [STEP_W-1:0]   period_count;
    logic                period_at_limit;

    gnr_step_counter #(.STEP_W(STEP_W)) u_period_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    ((state_reg == ST_CHECK) && !in_period_reg),
        .inc      (state_reg == ST_PERIOD),
        .limit    (max_reg),
        .count    (period_count),
        .at_limit (period_at_limit)
    );
`endif

    // Decision taken in CHECK; a match on the same cycle as the limit wins.
    always_comb begin
        fin_go      = 1'b0;
        fin_timeout = 1'b0;
        fin_period  = '0;
        go_period   = 1'b0;
`ifdef GNR_PERIOD_EN
        if (in_period_reg) begin
            if (alpha_eq) begin
                fin_go     = 1'b1;
                fin_period = period_count;
            end else if (period_at_limit) begin
                fin_go      = 1'b1;
                fin_timeout = 1'b1;
                fin_period  = max_reg;
            end else begin
                go_period = 1'b1;
            end
        end else if (alpha_eq && (step_count >= STEP_W'(2))) begin
            go_period = 1'b1;
        end else if (step_at_limit) begin
            fin_go      = 1'b1;
            fin_timeout = 1'b1;
        end
`else
        if (alpha_eq && (step_count >= STEP_W'(2))) begin
            fin_go = 1'b1;
        end else if (step_at_limit) begin
            fin_go      = 1'b1;
            fin_timeout = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cur_reg        <= '0;
            last_reg       <= '0;
            max_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            reset_nos_reg  <= 1'b0;
            start_s0_reg   <= 1'b0;
            start_s1_reg   <= 1'b0;
            init_state_reg <= '0;
            res_valid_reg  <= 1'b0;
            res_reg        <= '0;
`ifdef GNR_PERIOD_EN
            in_period_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        cur_reg        <= bus.cfg_first;
                        last_reg       <= bus.cfg_last;
                        max_reg        <= max_norm;
                        busy_reg       <= 1'b1;
                        reset_nos_reg  <= 1'b1;
                        init_state_reg <= bus.cfg_first;
                        state_reg      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    reset_nos_reg <= 1'b0;
                    start_s0_reg  <= 1'b1;
                    start_s1_reg  <= 1'b1;
                    state_reg     <= ST_STEP;
                end
                ST_STEP: begin
                    start_s0_reg <= 1'b0;
                    start_s1_reg <= 1'b0;
                    state_reg    <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (fin_go) begin
                        res_valid_reg   <= 1'b1;
                        res_reg.init    <= cur_reg;
                        res_reg.steps   <= step_count;
                        res_reg.period  <= fin_period;
                        res_reg.timeout <= fin_timeout;
                        state_reg       <= ST_RESULT;
`ifdef GNR_PERIOD_EN
                        in_period_reg   <= 1'b0;
`endif
                    end else if (go_period) begin
`ifdef GNR_PERIOD_EN
                        in_period_reg   <= 1'b1;
`endif
                        start_s1_reg    <= 1'b1;
                        state_reg       <= ST_PERIOD;
                    end else begin
                        start_s0_reg    <= 1'b1;
                        start_s1_reg    <= 1'b1;
                        state_reg       <= ST_STEP;
                    end
                end
                ST_PERIOD: begin
                    start_s1_reg <= 1'b0;
                    state_reg    <= ST_CHECK;
                end
                ST_RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_reg <= 1'b0;
                        if (cur_reg == last_reg) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_DONE;
                        end else begin
                            cur_reg        <= cur_inc;
                            init_state_reg <= cur_inc;
                            reset_nos_reg  <= 1'b1;
                            state_reg      <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.reset_nos   = reset_nos_reg;
    assign bus.start_s0    = start_s0_reg;
    assign bus.start_s1    = start_s1_reg;
    assign bus.init_state  = init_state_reg;
    assign bus.res_valid   = res_valid_reg;
    assign bus.res_init    = res_reg.init;
    assign bus.res_steps   = res_reg.steps;
    assign bus.res_period  = res_reg.period;
    assign bus.res_timeout = res_reg.timeout;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench: node bank modelled as identity / rotate-left / increment networks.
module tb_gnr_attractor_ctrl;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gnr_attractor_ctrl_if #(.N_NODES(N), .STEP_W(W)) bus ();
    gnr_attractor_ctrl #(.N_NODES(N), .STEP_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          net_mode = 0;
    logic [N-1:0] s0;
    logic [N-1:0] s1;

    function automatic logic [N-1:0] net_f(input logic [N-1:0] x);
        case (net_mode)
            1:       return {x[N-2:0], x[N-1]};
            2:       return x + N'(1);
            default: return x;
        endcase
    endfunction

    // Tortoise advances one network step per pulse, hare two.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= '0;
            s1 <= '0;
        end else if (bus.reset_nos) begin
            s0 <= bus.init_state;
            s1 <= bus.init_state;
        end else begin
            if (bus.start_s0) s0 <= net_f(s0);
            if (bus.start_s1) s1 <= net_f(net_f(s1));
        end
    end
    assign bus.alpha_s0 = s0;
    assign bus.alpha_s1 = s1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(bus.busy), 0);
        check_eq({tag, "_done"}, 32'(bus.done), 0);
        check_eq({tag, "_reset_nos"}, 32'(bus.reset_nos), 0);
        check_eq({tag, "_start_s0"}, 32'(bus.start_s0), 0);
        check_eq({tag, "_start_s1"}, 32'(bus.start_s1), 0);
        check_eq({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        check_eq({tag, "_init_state"}, 32'(bus.init_state), 0);
    endtask

    task automatic start_sweep(input logic [N-1:0] first, input logic [N-1:0] last,
                               input logic [W-1:0] mx);
        @(negedge clk);
        bus.cfg_first     = first;
        bus.cfg_last      = last;
        bus.cfg_max_steps = mx;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("busy_after_start", 32'(bus.busy), 1);
        check_eq("load_pulse", 32'(bus.reset_nos), 1);
        check_eq("load_init", 32'(bus.init_state), 32'(first));
    endtask

    task automatic wait_result();
        int n = 0;
        while (!bus.res_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("res_valid_arrives", 32'(bus.res_valid), 1);
    endtask

    task automatic take_result(input logic [N-1:0] e_init, input int e_steps,
                               input bit e_to, input bit is_last);
        logic [N-1:0] nxt;
        nxt = e_init + N'(1);
        wait_result();
        $display("result init=%0d steps=%0d period=%0d timeout=%0d",
                 bus.res_init, bus.res_steps, bus.res_period, bus.res_timeout);
        check_eq("res_init", 32'(bus.res_init), 32'(e_init));
        check_eq("res_steps", 32'(bus.res_steps), 32'(e_steps));
        check_eq("res_timeout", 32'(bus.res_timeout), 32'(e_to));
`ifndef GNR_PERIOD_EN
        check_eq("res_period", 32'(bus.res_period), 0);
`endif
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_eq("res_valid_drop", 32'(bus.res_valid), 0);
        check_eq("done_after_hs", 32'(bus.done), 32'(is_last));
        check_eq("busy_after_hs", 32'(bus.busy), 32'(!is_last));
        check_eq("reload_after_hs", 32'(bus.reset_nos), 32'(!is_last));
        if (is_last) begin
            @(negedge clk);
            check_eq("done_one_cycle", 32'(bus.done), 0);
        end else begin
            check_eq("next_init", 32'(bus.init_state), 32'(nxt));
        end
    endtask

    initial begin
        int pulses;
        int n;
        bus.start         = 1'b0;
        bus.cfg_first     = '0;
        bus.cfg_last      = '0;
        bus.cfg_max_steps = '0;
        bus.res_ready     = 1'b0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check_eq("reset_res_steps", 32'(bus.res_steps), 0);
        rst_n = 1'b1;

        // identity network: matches at step 2
        net_mode = 0;
        start_sweep(4'd3, 4'd3, 16'd10);
        take_result(4'd3, 2, 1'b0, 1'b1);

        // rotate-left: period 4, tortoise meets hare at step 4
        net_mode = 1;
        start_sweep(4'd1, 4'd1, 16'd10);
        take_result(4'd1, 4, 1'b0, 1'b1);

        // match coincides with limit: match wins
        net_mode = 0;
        start_sweep(4'd5, 4'd5, 16'd2);
        take_result(4'd5, 2, 1'b0, 1'b1);

        // limit 0 behaves as 1
        net_mode = 2;
        start_sweep(4'd9, 4'd9, 16'd0);
        take_result(4'd9, 1, 1'b1, 1'b1);

        // increment network times out; hold res_ready low 20 cycles
        net_mode = 2;
        start_sweep(4'd2, 4'd3, 16'd5);
        wait_result();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.reset_nos || bus.start_s0 || bus.start_s1) pulses++;
        end
        check_eq("hold_pulses", 32'(pulses), 0);
        check_eq("hold_valid", 32'(bus.res_valid), 1);
        check_eq("hold_init", 32'(bus.res_init), 2);
        check_eq("hold_steps", 32'(bus.res_steps), 5);
        check_eq("hold_timeout", 32'(bus.res_timeout), 1);
        take_result(4'd2, 5, 1'b1, 1'b0);
        take_result(4'd3, 5, 1'b1, 1'b1);

        // wrapping sweep 14 -> 1
        net_mode = 0;
        start_sweep(4'd14, 4'd1, 16'd10);
        take_result(4'd14, 2, 1'b0, 1'b0);
        take_result(4'd15, 2, 1'b0, 1'b0);
        take_result(4'd0, 2, 1'b0, 1'b0);
        take_result(4'd1, 2, 1'b0, 1'b1);

        // asynchronous reset during STEP of run 2, then re-sweep
        net_mode = 0;
        start_sweep(4'd5, 4'd7, 16'd10);
        take_result(4'd5, 2, 1'b0, 1'b0);
        n = 0;
        while (!bus.start_s0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("run2_step_seen", 32'(bus.start_s0), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("after_abort");
        start_sweep(4'd5, 4'd7, 16'd10);
        take_result(4'd5, 2, 1'b0, 1'b0);
        take_result(4'd6, 2, 1'b0, 1'b0);
        take_result(4'd7, 2, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
